// File: rtl/ddp_rx_parse_if.sv
// Bus bundle for the receive DDP parser: FIFO head, header handoff and payload stream.
// master is the parser's view; slave is the surrounding FIFO/RDMAP/payload-buffer side.
interface ddp_rx_parse_if;
    logic [266:0] rxPktDataOut;
    logic         rxPktEmpty;
    logic         rxPktPop;
    logic         rxDdp2RdmapHdrValid;
    logic [55:0]  rxDdp2RdmapHeader;
    logic [7:0]   rxDdp2RdmapCtrl;
    logic [7:0]   rxDdpCtrl;
    logic [15:0]  rxDdpHeader;
    logic         rxHdrReady;
    logic         payloadPush;
    logic [255:0] payloadData;
    logic [3:0]   payloadQN;
    logic [4:0]   payloadBytes;
    logic         payloadLast;
    logic         payloadFull;
    logic [15:0]  pktCount;
    logic [7:0]   errCount;

    modport master (
        input  rxPktDataOut, rxPktEmpty, rxHdrReady, payloadFull,
        output rxPktPop, rxDdp2RdmapHdrValid, rxDdp2RdmapHeader, rxDdp2RdmapCtrl,
               rxDdpCtrl, rxDdpHeader, payloadPush, payloadData, payloadQN,
               payloadBytes, payloadLast, pktCount, errCount
    );

    modport slave (
        output rxPktDataOut, rxPktEmpty, rxHdrReady, payloadFull,
        input  rxPktPop, rxDdp2RdmapHdrValid, rxDdp2RdmapHeader, rxDdp2RdmapCtrl,
               rxDdpCtrl, rxDdpHeader, payloadPush, payloadData, payloadQN,
               payloadBytes, payloadLast, pktCount, errCount
    );
endinterface

// File: rtl/ddp_rx_parse.sv
// Receive DDP parser: splits FIFO packet words into an RDMAP header handoff and a
// queue-tagged payload stream; malformed framing is dropped and counted.
//
// state   | meaning
// IDLE    | waiting for a packet head; SOP starts a header, non-SOP is an orphan
// HDR     | header presented to RDMAP, waiting for rxHdrReady
// PAYLOAD | forwarding payload words until EOP
// DROP    | discarding orphan words up to EOP
module ddp_rx_parse (
    input  logic           clock,
    input  logic           reset,
    ddp_rx_parse_if.master bus
);
    typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, DROP} state_t;

    state_t       state;
    logic         hdr_eop;
    logic         pop;
    logic         head_sop;
    logic         head_eop;
    logic [3:0]   head_qn;
    logic [4:0]   head_bc;
    logic [255:0] head_data;

    assign head_sop  = bus.rxPktDataOut[266];
    assign head_eop  = bus.rxPktDataOut[265];
    assign head_qn   = bus.rxPktDataOut[264:261];
    assign head_bc   = bus.rxPktDataOut[260:256];
    assign head_data = bus.rxPktDataOut[255:0];

    // A SOP head is never consumed outside IDLE so the next header is parsed there.
    always_comb begin
        pop = 1'b0;
        case (state)
            IDLE:    pop = !bus.rxPktEmpty;
            PAYLOAD: pop = !bus.rxPktEmpty && !bus.payloadFull && !head_sop;
            DROP:    pop = !bus.rxPktEmpty && !head_sop;
            default: pop = 1'b0;
        endcase
    end

    assign bus.rxPktPop = pop;

    always_ff @(posedge clock) begin
        if (reset) begin
            state                   <= IDLE;
            hdr_eop                 <= 1'b0;
            bus.rxDdp2RdmapHdrValid <= 1'b0;
            bus.rxDdp2RdmapHeader   <= '0;
            bus.rxDdp2RdmapCtrl     <= '0;
            bus.rxDdpCtrl           <= '0;
            bus.rxDdpHeader         <= '0;
            bus.payloadPush         <= 1'b0;
            bus.payloadData         <= '0;
            bus.payloadQN           <= '0;
            bus.payloadBytes        <= '0;
            bus.payloadLast         <= 1'b0;
            bus.pktCount            <= '0;
            bus.errCount            <= '0;
        end else begin
            bus.payloadPush <= 1'b0;
            bus.payloadLast <= 1'b0;
            case (state)
                IDLE: begin
                    if (!bus.rxPktEmpty) begin
                        if (head_sop) begin
                            bus.rxDdpCtrl           <= head_data[255:248];
                            bus.rxDdpHeader         <= head_data[247:232];
                            bus.rxDdp2RdmapCtrl     <= head_data[231:224];
                            bus.rxDdp2RdmapHeader   <= head_data[223:168];
                            bus.payloadQN           <= head_qn;
                            hdr_eop                 <= head_eop;
                            bus.rxDdp2RdmapHdrValid <= 1'b1;
                            state                   <= HDR;
                        end else begin
                            if (bus.errCount != 8'hFF) bus.errCount <= bus.errCount + 8'd1;
                            if (!head_eop) state <= DROP;
                        end
                    end
                end
                HDR: begin
                    if (bus.rxHdrReady) begin
                        bus.rxDdp2RdmapHdrValid <= 1'b0;
                        if (hdr_eop) begin
                            bus.pktCount <= bus.pktCount + 16'd1;
                            state        <= IDLE;
                        end else begin
                            state <= PAYLOAD;
                        end
                    end
                end
                PAYLOAD: begin
                    if (!bus.rxPktEmpty) begin
                        if (head_sop) begin
                            // Truncated packet: leave the new header for IDLE.
                            if (bus.errCount != 8'hFF) bus.errCount <= bus.errCount + 8'd1;
                            state <= IDLE;
                        end else if (!bus.payloadFull) begin
                            bus.payloadPush  <= 1'b1;
                            bus.payloadData  <= head_data;
                            bus.payloadBytes <= head_bc;
                            bus.payloadLast  <= head_eop;
                            if (head_eop) begin
                                bus.pktCount <= bus.pktCount + 16'd1;
                                state        <= IDLE;
                            end
                        end
                    end
                end
                DROP: begin
                    if (!bus.rxPktEmpty && (head_sop || head_eop)) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ddp_rx_parse.sv
// Directed bench for ddp_rx_parse: per-cycle vector table plus hand sequences for
// header values, payloadFull stalls and mid-packet reset.
module tb_ddp_rx_parse;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clock = ~clock;

    ddp_rx_parse_if bus ();

    ddp_rx_parse dut (.clock(clock), .reset(reset), .bus(bus));

    typedef struct {
        logic       empty, sop, eop;
        logic [3:0] qn;
        logic [4:0] bc;
        logic [7:0] tag;
        logic       rdy, full;
        logic       e_pop, e_hv;
        logic [7:0] e_htag;
        logic       e_push, e_last;
        logic [3:0] e_qn;
        logic [4:0] e_bytes;
        logic [7:0] e_ptag;
        logic [15:0] e_pkt;
        logic [7:0] e_err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic empty, logic sop, logic eop, logic [3:0] qn,
                                logic [4:0] bc, logic [7:0] tag, logic rdy, logic full,
                                logic e_pop, logic e_hv, logic [7:0] e_htag, logic e_push,
                                logic e_last, logic [3:0] e_qn, logic [4:0] e_bytes,
                                logic [7:0] e_ptag, logic [15:0] e_pkt, logic [7:0] e_err);
        vec_t v;
        v.empty = empty; v.sop = sop; v.eop = eop; v.qn = qn; v.bc = bc; v.tag = tag;
        v.rdy = rdy; v.full = full; v.e_pop = e_pop; v.e_hv = e_hv; v.e_htag = e_htag;
        v.e_push = e_push; v.e_last = e_last; v.e_qn = e_qn; v.e_bytes = e_bytes;
        v.e_ptag = e_ptag; v.e_pkt = e_pkt; v.e_err = e_err;
        return v;
    endfunction

    function automatic logic [266:0] mkword(logic sop, logic eop, logic [3:0] qn,
                                            logic [4:0] bc, logic [7:0] tag);
        return {sop, eop, qn, bc, {32{tag}}};
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic empty, input logic [266:0] w, input logic rdy,
                         input logic full);
        bus.rxPktEmpty   = empty;
        bus.rxPktDataOut = w;
        bus.rxHdrReady   = rdy;
        bus.payloadFull  = full;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [266:0] q[$];
        logic [7:0]   exp_tags[$];
        logic [266:0] hw;
        int           got;
        int           cyc;

        // empty, sop, eop, qn, bc, tag, rdy, full | pop, hv, htag, push, last, qn, bytes, ptag, pkt, err
        tbl.push_back(mk(1,0,0,0,5'h00,8'h00,1,0, 0,0,8'h00,0,0,0,5'h00,8'h00,0,0));
        tbl.push_back(mk(0,1,1,3,5'h00,8'hA1,1,0, 1,0,8'h00,0,0,0,5'h00,8'h00,0,0));
        tbl.push_back(mk(1,0,0,0,5'h00,8'h00,1,0, 0,1,8'hA1,0,0,0,5'h00,8'h00,0,0));
        tbl.push_back(mk(0,1,0,5,5'h00,8'hB0,1,0, 1,0,8'h00,0,0,0,5'h00,8'h00,1,0));
        tbl.push_back(mk(0,0,0,5,5'h1F,8'hB1,1,0, 0,1,8'hB0,0,0,0,5'h00,8'h00,1,0));
        tbl.push_back(mk(0,0,0,5,5'h1F,8'hB1,1,0, 1,0,8'h00,0,0,0,5'h00,8'h00,1,0));
        tbl.push_back(mk(0,0,1,5,5'h0F,8'hB2,1,0, 1,0,8'h00,1,0,5,5'h1F,8'hB1,1,0));
        tbl.push_back(mk(1,0,0,0,5'h00,8'h00,1,0, 0,0,8'h00,1,1,5,5'h0F,8'hB2,2,0));
        tbl.push_back(mk(0,1,0,9,5'h00,8'hC0,0,0, 1,0,8'h00,0,0,0,5'h00,8'h00,2,0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(0,0,1,9,5'h03,8'hC1,0,0, 0,1,8'hC0,0,0,0,5'h00,8'h00,2,0));
        tbl.push_back(mk(0,0,1,9,5'h03,8'hC1,1,0, 0,1,8'hC0,0,0,0,5'h00,8'h00,2,0));
        tbl.push_back(mk(0,0,1,9,5'h03,8'hC1,1,0, 1,0,8'h00,0,0,0,5'h00,8'h00,2,0));
        tbl.push_back(mk(1,0,0,0,5'h00,8'h00,1,0, 0,0,8'h00,1,1,9,5'h03,8'hC1,3,0));
        tbl.push_back(mk(0,0,0,0,5'h1F,8'hD1,1,0, 1,0,8'h00,0,0,0,5'h00,8'h00,3,0));
        tbl.push_back(mk(0,0,0,0,5'h1F,8'hD2,1,0, 1,0,8'h00,0,0,0,5'h00,8'h00,3,1));
        tbl.push_back(mk(0,0,1,0,5'h1F,8'hD3,1,0, 1,0,8'h00,0,0,0,5'h00,8'h00,3,1));
        tbl.push_back(mk(0,1,1,2,5'h00,8'hE0,1,0, 1,0,8'h00,0,0,0,5'h00,8'h00,3,1));
        tbl.push_back(mk(1,0,0,0,5'h00,8'h00,1,0, 0,1,8'hE0,0,0,0,5'h00,8'h00,3,1));
        tbl.push_back(mk(1,0,0,0,5'h00,8'h00,1,0, 0,0,8'h00,0,0,0,5'h00,8'h00,4,1));
        tbl.push_back(mk(0,1,0,4,5'h00,8'hF0,1,0, 1,0,8'h00,0,0,0,5'h00,8'h00,4,1));
        tbl.push_back(mk(0,0,0,4,5'h1F,8'hF1,1,0, 0,1,8'hF0,0,0,0,5'h00,8'h00,4,1));
        tbl.push_back(mk(0,0,0,4,5'h1F,8'hF1,1,0, 1,0,8'h00,0,0,0,5'h00,8'h00,4,1));
        tbl.push_back(mk(0,1,1,6,5'h00,8'h60,1,0, 0,0,8'h00,1,0,4,5'h1F,8'hF1,4,1));
        tbl.push_back(mk(0,1,1,6,5'h00,8'h60,1,0, 1,0,8'h00,0,0,0,5'h00,8'h00,4,2));
        tbl.push_back(mk(1,0,0,0,5'h00,8'h00,1,0, 0,1,8'h60,0,0,0,5'h00,8'h00,4,2));
        tbl.push_back(mk(1,0,0,0,5'h00,8'h00,1,0, 0,0,8'h00,0,0,0,5'h00,8'h00,5,2));

        drive(1'b1, '0, 1'b1, 1'b0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        #1;
        check("rst_pop",    256'(bus.rxPktPop), 0);
        check("rst_hv",     256'(bus.rxDdp2RdmapHdrValid), 0);
        check("rst_push",   256'(bus.payloadPush), 0);
        check("rst_last",   256'(bus.payloadLast), 0);
        check("rst_hdr",    256'({bus.rxDdp2RdmapHeader, bus.rxDdp2RdmapCtrl, bus.rxDdpCtrl, bus.rxDdpHeader}), 0);
        check("rst_data",   bus.payloadData, 0);
        check("rst_qnbytes", 256'({bus.payloadQN, bus.payloadBytes}), 0);
        check("rst_pkt",    256'(bus.pktCount), 0);
        check("rst_err",    256'(bus.errCount), 0);
        reset = 1'b0;

        foreach (tbl[i]) begin
            @(negedge clock);
            drive(tbl[i].empty, mkword(tbl[i].sop, tbl[i].eop, tbl[i].qn, tbl[i].bc, tbl[i].tag),
                  tbl[i].rdy, tbl[i].full);
            #1;
            check($sformatf("v%0d_pop", i),  256'(bus.rxPktPop), 256'(tbl[i].e_pop));
            check($sformatf("v%0d_hv", i),   256'(bus.rxDdp2RdmapHdrValid), 256'(tbl[i].e_hv));
            check($sformatf("v%0d_push", i), 256'(bus.payloadPush), 256'(tbl[i].e_push));
            check($sformatf("v%0d_last", i), 256'(bus.payloadLast), 256'(tbl[i].e_last));
            check($sformatf("v%0d_pkt", i),  256'(bus.pktCount), 256'(tbl[i].e_pkt));
            check($sformatf("v%0d_err", i),  256'(bus.errCount), 256'(tbl[i].e_err));
            if (tbl[i].e_hv) begin
                check($sformatf("v%0d_rhdr", i), 256'(bus.rxDdp2RdmapHeader), 256'({7{tbl[i].e_htag}}));
                check($sformatf("v%0d_dctl", i), 256'(bus.rxDdpCtrl), 256'(tbl[i].e_htag));
            end
            if (tbl[i].e_push) begin
                check($sformatf("v%0d_data", i),  bus.payloadData, {32{tbl[i].e_ptag}});
                check($sformatf("v%0d_qn", i),    256'(bus.payloadQN), 256'(tbl[i].e_qn));
                check($sformatf("v%0d_bytes", i), 256'(bus.payloadBytes), 256'(tbl[i].e_bytes));
            end
        end

        // Header-only packet with explicit field values.
        hw = '0;
        hw[266] = 1'b1; hw[265] = 1'b1; hw[264:261] = 4'd1;
        hw[255:248] = 8'h41; hw[247:232] = 16'h1234; hw[231:224] = 8'h42;
        hw[223:168] = 56'h00112233445566;
        @(negedge clock);
        drive(1'b0, hw, 1'b1, 1'b0);
        #1 check("ho_pop", 256'(bus.rxPktPop), 1);
        @(negedge clock);
        drive(1'b1, '0, 1'b1, 1'b0);
        #1;
        check("ho_hv",    256'(bus.rxDdp2RdmapHdrValid), 1);
        check("ho_rhdr",  256'(bus.rxDdp2RdmapHeader), 256'(56'h00112233445566));
        check("ho_rctl",  256'(bus.rxDdp2RdmapCtrl), 256'(8'h42));
        check("ho_dctl",  256'(bus.rxDdpCtrl), 256'(8'h41));
        check("ho_dhdr",  256'(bus.rxDdpHeader), 256'(16'h1234));
        @(negedge clock);
        #1;
        check("ho_hv_off", 256'(bus.rxDdp2RdmapHdrValid), 0);
        check("ho_push",   256'(bus.payloadPush), 0);
        check("ho_pkt",    256'(bus.pktCount), 6);

        // 10-word payload with payloadFull toggling every two cycles.
        q.push_back(mkword(1'b1, 1'b0, 4'd7, 5'h00, 8'h70));
        for (int k = 1; k <= 10; k++) begin
            q.push_back(mkword(1'b0, k == 10, 4'd7, (k == 10) ? 5'h10 : 5'h1F, 8'(8'h70 + k)));
            exp_tags.push_back(8'(8'h70 + k));
        end
        got = 0;
        cyc = 0;
        while (got < 10 && cyc < 80) begin
            @(negedge clock);
            if (q.size() != 0) drive(1'b0, q[0], 1'b1, ((cyc / 2) % 2) == 1);
            else               drive(1'b1, '0, 1'b1, ((cyc / 2) % 2) == 1);
            #1;
            check("full_nopop", 256'(bus.rxPktPop && bus.payloadFull && !bus.rxPktDataOut[266]), 0);
            check("empty_nopop", 256'(bus.rxPktPop && bus.rxPktEmpty), 0);
            if (bus.payloadPush) begin
                check($sformatf("fw%0d_data", got), bus.payloadData, {32{exp_tags[got]}});
                check($sformatf("fw%0d_last", got), 256'(bus.payloadLast), 256'(got == 9));
                check($sformatf("fw%0d_qn", got),   256'(bus.payloadQN), 7);
                got++;
            end
            if (bus.rxPktPop) q.pop_front();
            cyc++;
        end
        check("fw_count", 256'(got), 10);
        check("fw_bytes", 256'(bus.payloadBytes), 256'(5'h10));
        @(negedge clock);
        drive(1'b1, '0, 1'b1, 1'b0);
        #1;
        check("fw_nodup", 256'(bus.payloadPush), 0);
        check("fw_pkt",   256'(bus.pktCount), 7);

        // Reset while a header is held waiting for acceptance.
        @(negedge clock);
        drive(1'b0, mkword(1'b1, 1'b0, 4'd2, 5'h00, 8'h90), 1'b0, 1'b0);
        #1 check("mr_pop", 256'(bus.rxPktPop), 1);
        @(negedge clock);
        drive(1'b0, mkword(1'b0, 1'b0, 4'd2, 5'h1F, 8'h91), 1'b0, 1'b0);
        #1 check("mr_hv", 256'(bus.rxDdp2RdmapHdrValid), 1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        drive(1'b1, '0, 1'b1, 1'b0);
        #1;
        check("mr_hv_clr", 256'(bus.rxDdp2RdmapHdrValid), 0);
        check("mr_hdr_clr", 256'(bus.rxDdp2RdmapHeader), 0);
        check("mr_pkt", 256'(bus.pktCount), 0);
        check("mr_err", 256'(bus.errCount), 0);
        check("mr_pop_empty", 256'(bus.rxPktPop), 0);
        @(negedge clock);
        drive(1'b0, mkword(1'b1, 1'b1, 4'd3, 5'h00, 8'hA5), 1'b1, 1'b0);
        #1 check("mr_idle_pop", 256'(bus.rxPktPop), 1);
        @(negedge clock);
        drive(1'b1, '0, 1'b1, 1'b0);
        #1 check("mr_rhdr", 256'(bus.rxDdp2RdmapHeader), 256'({7{8'hA5}}));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ddp_rx_parse.md
# ddp_rx_parse

Receive-side DDP parser: the mirror of the transmit packet assembler. Pops 267-bit DDP packet words from the receive packet FIFO and splits each packet into a DDP/RDMAP header handed to the RDMAP receive logic and a stream of 256-bit payload words tagged with the destination queue. Sits between the receive packet FIFO and the RDMAP receive header stage and per-queue payload buffers. Malformed framing is dropped and counted.

## Interface
- No parameters; all widths fixed.
- clock  in  1  sole clock
- reset  in  1  synchronous, active-high
- rxPktDataOut  in  267  FIFO head word, first-word-fall-through; valid while rxPktEmpty=0
- rxPktEmpty  in  1  receive FIFO empty
- rxPktPop  out  1  consume head word (combinational)
- rxDdp2RdmapHdrValid  out  1  header valid, held until accepted
- rxDdp2RdmapHeader  out  56  RDMAP header
- rxDdp2RdmapCtrl  out  8  RDMAP control
- rxDdpCtrl  out  8  DDP control
- rxDdpHeader  out  16  DDP header
- rxHdrReady  in  1  RDMAP accepts header
- payloadPush  out  1  payload word valid (registered)
- payloadData  out  256  payload word
- payloadQN  out  4  destination queue of current packet
- payloadBytes  out  5  valid bytes minus 1 in payloadData
- payloadLast  out  1  last payload word of packet
- payloadFull  in  1  payload sink almost-full; at least 1 free entry remains when asserted
- pktCount  out  16  completed packets, wraps
- errCount  out  8  framing errors, saturates at 255

## Operation
- Word layout: [266] SOP, [265] EOP, [264:261] QN, [260:256] byte count minus 1, [255:0] data.
- Header word (SOP=1) data: [255:248] DDP ctrl, [247:232] DDP header, [231:224] RDMAP ctrl, [223:168] RDMAP header; [167:0] ignored. SOP=EOP=1 is a header-only packet.
- States: IDLE, HDR, PAYLOAD, DROP.
- IDLE, !empty, SOP=1: pop; register header fields, QN and EOP flag; -> HDR.
- IDLE, !empty, SOP=0: pop; errCount+1; EOP=1 stays IDLE, else -> DROP.
- HDR: rxDdp2RdmapHdrValid=1, fields stable. On rxHdrReady: captured EOP=1 -> IDLE, pktCount+1; else -> PAYLOAD. No pops in HDR.
- PAYLOAD, !empty, !payloadFull, SOP=0: pop; next cycle payloadPush=1 with data, QN from header, bytes from word, payloadLast=EOP. EOP -> IDLE, pktCount+1.
- PAYLOAD, head SOP=1 (missing EOP): no pop, no push; errCount+1; -> IDLE, which then parses the new header. Consumers see no payloadLast for the truncated packet.
- DROP: pop every available word until EOP (pop it, -> IDLE). A SOP head is not popped; -> IDLE.
- payloadFull stalls only PAYLOAD pops; the word in flight still pushes.
- Simultaneous pktCount and errCount events in one cycle update both independently.

## Timing
- Reset: state IDLE; rxPktPop, rxDdp2RdmapHdrValid, payloadPush, payloadLast 0; header fields, payloadData, payloadQN, payloadBytes 0; pktCount 0; errCount 0.
- Reset mid-packet returns to IDLE next cycle; partial header/payload discarded, no counts.
- Header latency: SOP word popped cycle t -> hdrValid from t+1.
- Payload latency: pop cycle t -> payloadPush cycle t+1; throughput 1 word/cycle.
- Minimum header-only packet: 2 cycles (IDLE pop, HDR accept with rxHdrReady already high).
- rxPktPop never asserted while rxPktEmpty=1.

## Test plan
- Header-only packet: SOP=EOP=1, RDMAP header 0x00112233445566, rxHdrReady=1 -> hdrValid one cycle after pop with that value, no payloadPush, pktCount=1.
- 3-word packet QN=5 (header + 2 payload, last byte count 0x0F): payloadPush on 2 consecutive cycles, payloadQN=5, second has payloadLast=1 and payloadBytes=0x0F.
- rxHdrReady low 4 cycles: hdrValid and fields stable, no pops; payload begins after acceptance.
- payloadFull toggled during a 10-word payload: no pops while high, all 10 words pushed in order, none lost or duplicated.
- Orphan payload words (SOP=0, 3 words, EOP on third) then valid packet: 3 pops, errCount=1, valid packet parsed normally.
- Packet truncated by new SOP: first packet stops without payloadLast, errCount+1, second packet header emitted, pktCount counts only the second.
